// File: rtl/ufm_write_seq.sv
// Writes a captured block of configuration words into the UFM data port, then
// polls the CSR busy field after each word, with bounded retry on poll timeout.
//
// state  | meaning
// IDLE   | waiting for start; image not held
// WRITE  | write strobe asserted, waiting for waitrequest low
// SETTLE | fixed wait before trusting csr_status
// POLL   | waiting for csr_status idle, timer running
// NEXT   | word complete; advance index or finish
// FINISH | done pulse, busy dropped
// FAIL   | retries exhausted, error latched
module ufm_write_seq #(
  parameter int NUM_WORDS      = 6,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int BASE_ADDR      = 0,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int MAX_RETRY      = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [NUM_WORDS*DATA_W-1:0] image,
  output logic                        ufmwrite,
  output logic [ADDR_W-1:0]           write_addr,
  output logic [DATA_W-1:0]           writedata,
  input  logic                        waitrequest,
  input  logic [1:0]                  csr_status,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [7:0]                  err_index,
  output logic [7:0]                  words_written
);

  localparam int TMR_SPAN = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W    = $clog2(TMR_SPAN + 1);
  localparam int RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  generate
    if (NUM_WORDS < 1 || NUM_WORDS > 256) begin : g_bad_num_words
      $error("ufm_write_seq: NUM_WORDS must be within 1..256");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_SETTLE, S_POLL, S_NEXT, S_FINISH, S_FAIL
  } state_t;

  state_t                      state;
  logic [NUM_WORDS*DATA_W-1:0] shadow;
  logic [7:0]                  idx;
  logic [RTY_W-1:0]            retry;
  logic [TMR_W-1:0]            timer;
  logic [7:0]                  idx_nxt;

  assign idx_nxt = idx + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      shadow        <= '0;
      idx           <= '0;
      retry         <= '0;
      timer         <= '0;
      ufmwrite      <= 1'b0;
      write_addr    <= BASE;
      writedata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_index     <= '0;
      words_written <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow        <= image;
            idx           <= '0;
            retry         <= '0;
            error         <= 1'b0;
            words_written <= '0;
            busy          <= 1'b1;
            ufmwrite      <= 1'b1;
            write_addr    <= BASE;
            writedata     <= image[DATA_W-1:0];
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!waitrequest) begin
            ufmwrite <= 1'b0;
            timer    <= '0;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (timer == TMR_W'(SETTLE_CYCLES - 1)) begin
            timer <= '0;
            state <= S_POLL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_POLL: begin
          if (csr_status == 2'b00) begin
            state <= S_NEXT;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            // address and data registers still hold the word being retried
            if (retry < RTY_W'(MAX_RETRY)) begin
              retry    <= retry + 1'b1;
              ufmwrite <= 1'b1;
              state    <= S_WRITE;
            end else begin
              err_index <= idx;
              error     <= 1'b1;
              busy      <= 1'b0;
              state     <= S_FAIL;
            end
          end else if (timer != {TMR_W{1'b1}}) begin
            timer <= timer + 1'b1;
          end
        end
        S_NEXT: begin
          words_written <= words_written + 8'd1;
          retry         <= '0;
          if (idx == 8'(NUM_WORDS - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FINISH;
          end else begin
            idx        <= idx_nxt;
            ufmwrite   <= 1'b1;
            write_addr <= BASE + ADDR_W'(idx_nxt);
            writedata  <= shadow[int'(idx_nxt)*DATA_W +: DATA_W];
            state      <= S_WRITE;
          end
        end
        S_FINISH: state <= S_IDLE;
        S_FAIL: begin
          ufmwrite <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_write_seq.sv
// Directed bench for ufm_write_seq: default instance plus a short-timeout
// instance for the retry/failure path.
module tb_ufm_write_seq;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          start_to = 1'b0;
  logic [191:0]  image = '0;
  logic          waitrequest = 1'b0;
  logic [1:0]    csr_status = 2'b00;
  logic [1:0]    csr_status_to = 2'b00;

  logic          ufmwrite, busy, done, error;
  logic [15:0]   write_addr;
  logic [31:0]   writedata;
  logic [7:0]    err_index, words_written;

  logic          ufmwrite_to, busy_to, done_to, error_to;
  logic [15:0]   write_addr_to;
  logic [31:0]   writedata_to;
  logic [7:0]    err_index_to, words_written_to;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  int done_cnt = 0;
  int done_to_cnt = 0;
  logic [31:0] exp_w[6];
  logic [15:0] la[$];
  logic [31:0] ld[$];
  logic [15:0] la_to[$];
  logic [31:0] ld_to[$];

  always #5 clk = ~clk;

  ufm_write_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .image(image),
    .ufmwrite(ufmwrite), .write_addr(write_addr), .writedata(writedata),
    .waitrequest(waitrequest), .csr_status(csr_status),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index), .words_written(words_written)
  );

  ufm_write_seq #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2)) dut_to (
    .clk(clk), .reset_n(reset_n), .start(start_to), .image(image),
    .ufmwrite(ufmwrite_to), .write_addr(write_addr_to), .writedata(writedata_to),
    .waitrequest(waitrequest), .csr_status(csr_status_to),
    .busy(busy_to), .done(done_to), .error(error_to),
    .err_index(err_index_to), .words_written(words_written_to)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (done_to) done_to_cnt <= done_to_cnt + 1;
    if (ufmwrite && !waitrequest) begin
      la.push_back(write_addr);
      ld.push_back(writedata);
    end
    if (ufmwrite_to && !waitrequest) begin
      la_to.push_back(write_addr_to);
      ld_to.push_back(writedata_to);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_image();
    for (int i = 0; i < 6; i++) image[i*32 +: 32] = exp_w[i];
  endtask

  // returns on the falling edge right after the accepting rising edge
  task automatic pulse_start(input bit to);
    @(negedge clk);
    if (to) start_to = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_to = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input bit to, input int limit);
    int n;
    n = 0;
    while (!(to ? done_to : done) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(to ? "done_to_seen" : "done_seen", to ? done_to : done, 1'b1);
  endtask

  task automatic wait_strobe(input logic [15:0] addr, input int limit);
    int n;
    n = 0;
    while (!(ufmwrite && write_addr == addr) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", ufmwrite && write_addr == addr, 1'b1);
  endtask

  task automatic check_log(input bit to);
    chk(to ? "log_to_len" : "log_len", to ? la_to.size() : la.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < (to ? la_to.size() : la.size())) begin
        chk("log_addr", to ? la_to[i] : la[i], 16'(i));
        chk("log_data", to ? ld_to[i] : ld[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w3;
    bit ok;
    int tr;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ufmwrite", ufmwrite, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_index", err_index, 0);
    chk("rst_words", words_written, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic sequence, 5 cycles per word
    exp_w = '{32'h1E, 32'h4C4B40, 32'h100100, 32'h100100, 32'h100100, 32'h100100};
    load_image();
    la.delete(); ld.delete();
    done_cnt = 0;
    pulse_start(0);
    chk("busy_after_start", busy, 1);
    wait_done(0, 100);
    chk("done_latency", cyc - t0, 30);
    chk("done_busy_low", busy, 0);
    chk("done_words", words_written, 6);
    chk("done_error", error, 0);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("done_cleared", done, 0);
    check_log(0);

    // waitrequest stall on word 2
    exp_w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    load_image();
    la.delete(); ld.delete();
    pulse_start(0);
    wait_strobe(16'd2, 50);
    waitrequest = 1'b1;
    ok = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (!(ufmwrite && write_addr == 16'd2 && writedata == 32'hA2)) ok = 1'b0;
    end
    waitrequest = 1'b0;
    chk("stall_stable", ok, 1);
    wait_done(0, 100);
    chk("stall_latency", cyc - t0, 37);
    check_log(0);

    // CSR busy for 50 cycles after word 0
    la.delete(); ld.delete();
    pulse_start(0);
    chk("w0_strobe", ufmwrite, 1);
    csr_status = 2'b10;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (ufmwrite || write_addr != 16'd0) ok = 1'b0;
    end
    chk("poll_hold", ok, 1);
    chk("poll_log_len", la.size(), 1);
    csr_status = 2'b00;
    tr = cyc;
    wait_strobe(16'd1, 10);
    chk("w1_after_idle", cyc - tr, 2);
    wait_done(0, 100);
    chk("poll_words", words_written, 6);
    check_log(0);

    // retry exhaustion on word 3 (short-timeout instance)
    la_to.delete(); ld_to.delete();
    done_to_cnt = 0;
    pulse_start(1);
    tr = 0;
    while (!(ufmwrite_to && write_addr_to == 16'd3) && tr < 50) begin
      @(negedge clk);
      tr++;
    end
    csr_status_to = 2'b10;
    tr = 0;
    while (!error_to && tr < 200) begin
      @(negedge clk);
      tr++;
    end
    chk("fail_error", error_to, 1);
    chk("fail_err_index", err_index_to, 3);
    chk("fail_words", words_written_to, 3);
    chk("fail_busy", busy_to, 0);
    w3 = 0;
    foreach (la_to[i]) if (la_to[i] == 16'd3) w3++;
    chk("fail_w3_writes", w3, 3);
    chk("fail_total_writes", la_to.size(), 6);
    repeat (3) @(negedge clk);
    chk("fail_no_done", done_to_cnt, 0);
    chk("fail_error_sticky", error_to, 1);
    csr_status_to = 2'b00;

    // start during busy is ignored
    la.delete(); ld.delete();
    pulse_start(0);
    repeat (8) @(negedge clk);
    exp_w = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
    load_image();
    pulse_start(0);
    exp_w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    wait_done(0, 100);
    check_log(0);
    exp_w = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
    la.delete(); ld.delete();
    repeat (2) @(negedge clk);
    pulse_start(0);
    wait_done(0, 100);
    check_log(0);

    // new start clears a latched error
    la_to.delete(); ld_to.delete();
    pulse_start(1);
    chk("restart_error_clear", error_to, 0);
    wait_done(1, 100);
    chk("restart_words", words_written_to, 6);
    check_log(1);

    // reset in the middle of a stalled write on word 4
    la.delete(); ld.delete();
    pulse_start(0);
    wait_strobe(16'd4, 50);
    waitrequest = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ufmwrite", ufmwrite, 0);
    chk("arst_addr", write_addr, 0);
    chk("arst_data", writedata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_words", words_written, 0);
    @(negedge clk);
    reset_n = 1'b1;
    waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_idle", ufmwrite, 0);
    la.delete(); ld.delete();
    pulse_start(0);
    chk("arst_restart_addr", write_addr, 0);
    wait_done(0, 100);
    check_log(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
